// File: rtl/matrix_op_seq_if.sv
// Bus bundle for matrix_op_seq: operation request, memory port, status
// flags and the result display byte.
interface matrix_op_seq_if #(
  parameter int ADDR_W = 8,
  parameter int MAT_W  = 256
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [MAT_W-1:0]  mem_wdata;
  logic [MAT_W-1:0]  mem_rdata;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              disp_en;
  logic [7:0]        disp_byte;

  modport master (
    output start, op, addr_a, addr_b, addr_c, mem_rdata, disp_en,
    input  mem_addr, mem_we, mem_wdata, busy, done, ovf, disp_byte
  );

  modport slave (
    input  start, op, addr_a, addr_b, addr_c, mem_rdata, disp_en,
    output mem_addr, mem_we, mem_wdata, busy, done, ovf, disp_byte
  );
endinterface

// File: rtl/matrix_op_seq.sv
// Matrix operation sequencer: reads two N x N matrices from memory,
// applies add / sub / element multiply / transpose and writes the result
// back, then scans the result bytes onto an 8-bit display.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; mem_addr holds its last value
// RD_A   | mem_addr = addr_a for MEM_LAT+1 cycles, A captured on the last
// RD_B   | mem_addr = addr_b for MEM_LAT+1 cycles, B captured on the last
// EXEC   | element-wise result and overflow registered
// WR     | mem_we pulse to addr_c with the result
// FIN    | done pulse; ovf and display restart become visible
module matrix_op_seq #(
  parameter int ELEM_W   = 16,
  parameter int N        = 4,
  parameter int ADDR_W   = 8,
  parameter int MEM_LAT  = 2,
  parameter int DISP_DIV = 25_000_000
) (
  input logic            clk,
  input logic            rst,
  matrix_op_seq_if.slave bus
);

  localparam int MAT_W  = ELEM_W * N * N;
  localparam int NBYTES = MAT_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DIV_W  = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

  localparam logic [2:0]       LAT_LOAD = 3'(MEM_LAT);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DISP_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WR,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]        wait_cnt;
  logic              wait_tc;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [ADDR_W-1:0] addr_c_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [MAT_W-1:0]  a_q;
  logic [MAT_W-1:0]  b_q;
  logic [MAT_W-1:0]  result_q;
  logic              ovf_pend;
  logic              ovf_q;

  logic              busy_c;
  logic              done_c;
  logic              we_c;

  logic [MAT_W-1:0]  res_c;
  logic              ovf_c;
  logic [ELEM_W-1:0] ea;
  logic [ELEM_W-1:0] eb;
  logic [ELEM_W-1:0] et;
  logic [ELEM_W:0]   sum;
  logic [2*ELEM_W-1:0] prod;

  logic [IDX_W-1:0]  disp_idx;
  logic [IDX_W-1:0]  disp_idx_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [7:0]        disp_q;

  assign wait_tc = (wait_cnt == 3'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and the per-state strobes.
  always_comb begin
    state_nx = state;
    busy_c   = 1'b1;
    done_c   = 1'b0;
    we_c     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nx = S_RD_A;
      end
      S_RD_A: if (wait_tc) state_nx = S_RD_B;
      S_RD_B: if (wait_tc) state_nx = S_EXEC;
      S_EXEC: state_nx = S_WR;
      S_WR: begin
        we_c     = 1'b1;
        state_nx = S_FIN;
      end
      S_FIN: begin
        done_c   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latching, read-latency timer, memory address and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= 3'd0;
      op_q       <= 2'b00;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
      mem_addr_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ovf_pend   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q       <= bus.op;
            addr_b_q   <= bus.addr_b;
            addr_c_q   <= bus.addr_c;
            mem_addr_q <= bus.addr_a;
            wait_cnt   <= LAT_LOAD;
          end
        end
        S_RD_A: begin
          if (wait_tc) begin
            a_q        <= bus.mem_rdata;
            mem_addr_q <= addr_b_q;
            wait_cnt   <= LAT_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_RD_B: begin
          if (wait_tc) b_q <= bus.mem_rdata;
          else         wait_cnt <= wait_cnt - 3'd1;
        end
        S_EXEC: begin
          result_q   <= res_c;
          ovf_pend   <= ovf_c;
          mem_addr_q <= addr_c_q;
        end
        S_WR: ovf_q <= ovf_pend;
        default: ;
      endcase
    end
  end

  // Element-wise arithmetic; transpose reads A with row and column swapped.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ea    = '0;
    eb    = '0;
    et    = '0;
    sum   = '0;
    prod  = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ea   = a_q[(r*N+c)*ELEM_W +: ELEM_W];
        eb   = b_q[(r*N+c)*ELEM_W +: ELEM_W];
        et   = a_q[(c*N+r)*ELEM_W +: ELEM_W];
        sum  = {1'b0, ea} + {1'b0, eb};
        prod = {{ELEM_W{1'b0}}, ea} * {{ELEM_W{1'b0}}, eb};
        case (op_q)
          2'b00: begin
            res_c[(r*N+c)*ELEM_W +: ELEM_W] = sum[ELEM_W-1:0];
            if (sum[ELEM_W]) ovf_c = 1'b1;
          end
          2'b01: begin
            res_c[(r*N+c)*ELEM_W +: ELEM_W] = ea - eb;
            if (ea < eb) ovf_c = 1'b1;
          end
          2'b10: begin
            res_c[(r*N+c)*ELEM_W +: ELEM_W] = prod[ELEM_W-1:0];
            if (|prod[2*ELEM_W-1:ELEM_W]) ovf_c = 1'b1;
          end
          default: res_c[(r*N+c)*ELEM_W +: ELEM_W] = et;
        endcase
      end
    end
  end

  assign disp_idx_nx = (disp_idx == IDX_LAST) ? '0 : disp_idx + 1'b1;

  // Display scan: restarts at byte 0 alongside done, then steps through the
  // result bytes once per DISP_DIV idle cycles while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_idx <= '0;
      disp_q   <= 8'h00;
      div_cnt  <= '0;
    end else if (state == S_WR) begin
      disp_idx <= '0;
      disp_q   <= result_q[7:0];
      div_cnt  <= DIV_LOAD;
    end else if (bus.disp_en && !busy_c) begin
      if (div_cnt == '0) begin
        disp_idx <= disp_idx_nx;
        disp_q   <= result_q[{disp_idx_nx, 3'b000} +: 8];
        div_cnt  <= DIV_LOAD;
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = we_c;
  assign bus.mem_wdata = result_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.ovf       = ovf_q;
  assign bus.disp_byte = disp_q;

endmodule

// File: tb/tb_matrix_op_seq.sv
// Directed bench for matrix_op_seq with a behavioural latency memory and a
// write scoreboard.
module tb_matrix_op_seq;
  localparam int ELEM_W   = 16;
  localparam int N        = 4;
  localparam int ADDR_W   = 8;
  localparam int MEM_LAT  = 2;
  localparam int DISP_DIV = 4;
  localparam int MAT_W    = ELEM_W * N * N;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MAT_W-1:0]  data;
    logic              ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  matrix_op_seq_if #(.ADDR_W(ADDR_W), .MAT_W(MAT_W)) bus ();

  matrix_op_seq #(
    .ELEM_W(ELEM_W), .N(N), .ADDR_W(ADDR_W),
    .MEM_LAT(MEM_LAT), .DISP_DIV(DISP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [MAT_W-1:0]  mem  [0:(1<<ADDR_W)-1];
  logic [MAT_W-1:0]  pipe [0:MEM_LAT-1];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [MAT_W-1:0]  ld_data = '0;

  // Memory with MEM_LAT cycles from address to read data.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] fill(input logic [ELEM_W-1:0] v);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < N*N; i++) m[i*ELEM_W +: ELEM_W] = v;
    return m;
  endfunction

  task automatic load(input logic [ADDR_W-1:0] a, input logic [MAT_W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_disp"}, bus.disp_byte, 0);
  endtask

  // Issues one operation at edge T and watches 20 cycles after it.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                        input logic [ADDR_W-1:0] ac, input logic [MAT_W-1:0] exp_data,
                        input logic exp_ovf, input bit exp_write,
                        input int busy_start_k, input int rst_k);
    int   we_cnt, done_cnt, we_k, done_k;
    logic ovf_at_done;
    logic [7:0] disp_at_done;
    exp_t e;
    we_cnt = 0; done_cnt = 0; we_k = -1; done_k = -1;
    ovf_at_done = 1'bx; disp_at_done = 8'hxx;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op;
    bus.addr_a = aa; bus.addr_b = ab; bus.addr_c = ac;
    if (exp_write) begin
      e.addr = ac; e.data = exp_data; e.ovf = exp_ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk({tag, "_addr_a"}, bus.mem_addr, aa);
      if (k == MEM_LAT + 1) chk({tag, "_addr_b"}, bus.mem_addr, ab);
      if (bus.mem_we) begin
        we_cnt++;
        we_k = k;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_wr_addr"}, bus.mem_addr, e.addr);
          chk({tag, "_wr_data"}, bus.mem_wdata, e.data);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_k = k;
        ovf_at_done = bus.ovf;
        disp_at_done = bus.disp_byte;
      end
      if (k == busy_start_k) bus.start = 1'b1;
      if (k == busy_start_k + 1) bus.start = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
    end
    chk({tag, "_we_count"}, we_cnt, exp_write ? 1 : 0);
    chk({tag, "_done_count"}, done_cnt, exp_write ? 1 : 0);
    if (exp_write) begin
      chk({tag, "_we_cycle"}, we_k, 3 + 2*MEM_LAT);
      chk({tag, "_done_cycle"}, done_k, 4 + 2*MEM_LAT);
      chk({tag, "_ovf_at_done"}, ovf_at_done, exp_ovf);
      chk({tag, "_ovf_held"}, bus.ovf, exp_ovf);
      chk({tag, "_disp_at_done"}, disp_at_done, exp_data[7:0]);
    end
    if (rst_k > 0) check_all_zero({tag, "_after_rst"});
    sb.delete();
  endtask

  initial begin
    logic [MAT_W-1:0] ta, tc, bytes;
    bus.start = 1'b0; bus.op = 2'b00;
    bus.addr_a = '0; bus.addr_b = '0; bus.addr_c = '0;
    bus.disp_en = 1'b0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    load(8'd0, fill(16'h0001));
    load(8'd1, fill(16'h0002));
    load(8'd3, fill(16'h0000));
    load(8'd4, fill(16'h0001));
    load(8'd6, fill(16'h0100));
    load(8'd8, fill(16'h0003));
    load(8'd9, fill(16'h0005));
    ta = '0;
    ta[(0*N+1)*ELEM_W +: ELEM_W] = 16'h1234;
    ta[(3*N+2)*ELEM_W +: ELEM_W] = 16'hBEEF;
    tc = '0;
    tc[(1*N+0)*ELEM_W +: ELEM_W] = 16'h1234;
    tc[(2*N+3)*ELEM_W +: ELEM_W] = 16'hBEEF;
    load(8'd11, ta);
    bytes = '0;
    for (int i = 0; i < MAT_W/8; i++) bytes[i*8 +: 8] = 8'(i);
    load(8'd20, bytes);
    load(8'd21, '0);

    run_op("add",      2'b00, 8'd0,  8'd1, 8'd2,  fill(16'h0003), 1'b0, 1'b1, 0, 0);
    run_op("sub",      2'b01, 8'd3,  8'd4, 8'd5,  fill(16'hFFFF), 1'b1, 1'b1, 0, 0);
    run_op("mul_ovf",  2'b10, 8'd6,  8'd6, 8'd7,  fill(16'h0000), 1'b1, 1'b1, 0, 0);
    run_op("mul",      2'b10, 8'd8,  8'd9, 8'd10, fill(16'h000F), 1'b0, 1'b1, 0, 0);
    run_op("transpose",2'b11, 8'd11, 8'd1, 8'd12, tc,             1'b0, 1'b1, 0, 0);
    run_op("busy_start",2'b00,8'd0,  8'd1, 8'd13, fill(16'h0003), 1'b0, 1'b1, 2, 0);
    run_op("mid_rst",  2'b01, 8'd3,  8'd4, 8'd14, '0,             1'b0, 1'b0, 0, 4);
    run_op("disp_load",2'b00, 8'd20, 8'd21,8'd22, bytes,          1'b0, 1'b1, 0, 0);

    bus.disp_en = 1'b1;
    for (int s = 1; s <= 33; s++) begin
      repeat (3) @(posedge clk);
      #1 chk($sformatf("disp_hold_%0d", s), bus.disp_byte, 8'((s - 1) % 32));
      @(posedge clk);
      #1 chk($sformatf("disp_step_%0d", s), bus.disp_byte, 8'(s % 32));
    end
    bus.disp_en = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("disp_frozen", bus.disp_byte, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_op_seq.md
MATRIX_OP_SEQ -- requirements
Module: matrix_op_seq

Interface
REQ-001 Parameter ELEM_W, default 16, is the element width in bits.
REQ-002 Parameter N, default 4, is the matrix dimension (N x N); MAT_W = ELEM_W*N*N, which SHALL be a multiple of 8.
REQ-003 Parameter ADDR_W, default 8, is the memory address width.
REQ-004 Parameter MEM_LAT, default 2 (range 1..7), is the memory read latency in clk cycles from address to valid mem_rdata.
REQ-005 Parameter DISP_DIV, default 25_000_000, is the number of clk cycles per display advance.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port start, input, 1 bit: operation request, sampled in IDLE only.
REQ-009 Port op, input, 2 bits: 00 add, 01 sub (A-B), 10 element multiply, 11 transpose A; sampled with start.
REQ-010 Ports addr_a, addr_b, addr_c, input, ADDR_W bits each: source A, source B and destination C words; sampled with start.
REQ-011 Port mem_addr, output, ADDR_W bits: memory address.
REQ-012 Port mem_we, output, 1 bit: memory write enable.
REQ-013 Port mem_wdata, output, MAT_W bits: write data.
REQ-014 Port mem_rdata, input, MAT_W bits: read data.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port done, output, 1 bit: one-cycle completion pulse.
REQ-017 Port ovf, output, 1 bit: overflow flag for the last completed operation.
REQ-018 Port disp_en, input, 1 bit: enables the display scan.
REQ-019 Port disp_byte, output, 8 bits: currently displayed result byte.

Function
REQ-020 Element (r,c) SHALL occupy bits [(r*N+c)*ELEM_W +: ELEM_W] of every matrix word.
REQ-021 The FSM SHALL use states IDLE, RD_A, RD_B, EXEC, WR, FIN.
- IDLE -> RD_A when start=1; op and addresses are latched.
- RD_A -> RD_B and RD_B -> EXEC each after MEM_LAT+1 cycles.
- EXEC -> WR -> FIN -> IDLE, one cycle each.
REQ-022 In RD_A (RD_B), mem_addr SHALL equal latched addr_a (addr_b), and mem_rdata SHALL be captured into A (B) on the last cycle of the state.
REQ-023 Timing SHALL be as follows, with start accepted at edge T:
- mem_we=1 for exactly one cycle at T+3+2*MEM_LAT, with mem_addr=addr_c and mem_wdata=result.
- done=1 at T+4+2*MEM_LAT; default MEM_LAT=2 gives T+8.
REQ-024 In every state except WR, mem_we SHALL be 0; mem_addr SHALL hold its last value in IDLE.
REQ-025 Arithmetic is per element and modulo 2^ELEM_W:
- Add: ovf if any element carries out.
- Sub: ovf if any element borrows (A<B, unsigned).
- Multiply: keep the low ELEM_W bits of the 2*ELEM_W product; ovf if any upper bits are nonzero.
- Transpose: C(r,c)=A(c,r); B is read but ignored; ovf=0.
REQ-026 ovf SHALL be updated at done and held until the next done.
REQ-027 start while busy=1 SHALL be ignored and SHALL NOT be queued; start=1 held in IDLE SHALL restart immediately after FIN.
REQ-028 On done, the display index SHALL reset to 0 and disp_byte SHALL show result bits [7:0].
REQ-029 With disp_en=1 and busy=0, the index SHALL advance every DISP_DIV cycles and wrap from MAT_W/8-1 to 0; the display divider counter SHALL restart on done.
REQ-030 With disp_en=0 or busy=1, the index and disp_byte SHALL hold; the divider counter SHALL NOT advance.

Reset
REQ-031 rst=1 at any edge SHALL force: IDLE; busy=0, done=0, ovf=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_byte=0; A, B, result and index cleared; divider=0.
REQ-032 Reset mid-operation SHALL abort with no memory write and no done pulse.

Verification
REQ-033 Add: A all 0x0001, B all 0x0002, addr_c=2 -> mem_we at T+7 with addr 2 and data all 0x0003, done at T+8, ovf=0.
REQ-034 Sub and multiply:
- A=0, B all 0x0001 -> C all 0xFFFF, ovf=1.
- Multiply 0x0100*0x0100 -> C all 0x0000, ovf=1.
- Multiply 0x0003*0x0005 -> C all 0x000F, ovf=0.
REQ-035 Transpose: A(0,1)=0x1234, A(3,2)=0xBEEF -> C(1,0)=0x1234, C(2,3)=0xBEEF, ovf=0.
REQ-036 start pulse at T+3 during busy -> exactly one write and one done; rst at T+5 -> no mem_we, no done, all outputs 0.
REQ-037 Display with DISP_DIV=4, result bytes 0x00..0x1F:
- disp_byte steps 0x00,0x01,... every 4 cycles and wraps 0x1F->0x00 after 32 steps.
- disp_en=0 freezes disp_byte.
